// File: rtl/txepacket.sv
// Transmit packet filter: turns a VALID/READY/LAST/ABORT byte stream into the
// unstallable one-byte-per-strobe PHY stream, with inter-frame gap and truncation flag.
module txepacket #(
   parameter int GAP_BYTES = 12
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_ce,
   input  logic       S_AXIN_VALID,
   output logic       S_AXIN_READY,
   input  logic [7:0] S_AXIN_DATA,
   input  logic       S_AXIN_LAST,
   input  logic       S_AXIN_ABORT,
   output logic       o_v,
   output logic [7:0] o_d,
   output logic       o_err,
   output logic       o_busy
);

   localparam int GAP_EFF = (GAP_BYTES < 1) ? 1 : GAP_BYTES;
   localparam int CW = ($clog2(GAP_EFF + 1) < 1) ? 1 : $clog2(GAP_EFF + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(GAP_EFF - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, DRAIN = 2'd2, GAP = 2'd3} state_t;

   state_t          state_q, state_d;
   logic            h_v_q, h_v_d;
   logic [7:0]      h_d_q, h_d_d;
   logic            h_l_q, h_l_d;
   logic            sent_last_q, sent_last_d;
   logic            abort_pend_q, abort_pend_d;
   logic            abort_seen_q, abort_seen_d;
   logic            cause_abort_q, cause_abort_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            o_v_q, o_v_d;
   logic [7:0]      o_d_q, o_d_d;
   logic            o_err_q, o_err_d;

   logic accept, load, abort_now, ev_send, ev_end, ev_trunc, drain_done;

   // The holding register is never bypassed, so a byte can be taken at most
   // every second clock; strobes faster than that will underrun.
   assign S_AXIN_READY = !h_v_q || (state_q == DRAIN) || S_AXIN_ABORT;
   assign accept       = S_AXIN_VALID && S_AXIN_READY;
   assign load         = accept && (state_q != DRAIN) && !S_AXIN_ABORT;
   assign abort_now    = S_AXIN_ABORT || abort_pend_q;

   assign ev_send  = i_ce && h_v_q && !S_AXIN_ABORT &&
                     ((state_q == IDLE) || ((state_q == DATA) && !sent_last_q && !abort_pend_q));
   assign ev_end   = i_ce && (state_q == DATA) && sent_last_q;
   assign ev_trunc = i_ce && (state_q == DATA) && !sent_last_q && !ev_send;

   // An underrun drain may also end on a LAST beat caught in the holding reg on entry.
   assign drain_done = cause_abort_q ? !S_AXIN_ABORT
                     : ((accept && S_AXIN_LAST) || (h_v_q && h_l_q) ||
                        (abort_seen_q && !S_AXIN_ABORT));

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q       <= IDLE;
         h_v_q         <= 1'b0;
         h_d_q         <= 8'd0;
         h_l_q         <= 1'b0;
         sent_last_q   <= 1'b0;
         abort_pend_q  <= 1'b0;
         abort_seen_q  <= 1'b0;
         cause_abort_q <= 1'b0;
         cnt_q         <= '0;
         o_v_q         <= 1'b0;
         o_d_q         <= 8'd0;
         o_err_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         h_v_q         <= h_v_d;
         h_d_q         <= h_d_d;
         h_l_q         <= h_l_d;
         sent_last_q   <= sent_last_d;
         abort_pend_q  <= abort_pend_d;
         abort_seen_q  <= abort_seen_d;
         cause_abort_q <= cause_abort_d;
         cnt_q         <= cnt_d;
         o_v_q         <= o_v_d;
         o_d_q         <= o_d_d;
         o_err_q       <= o_err_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      cause_abort_d = cause_abort_q;
      abort_seen_d  = abort_seen_q;
      sent_last_d   = sent_last_q;
      h_v_d         = h_v_q;
      h_d_d         = h_d_q;
      h_l_d         = h_l_q;
      abort_pend_d  = (state_q == DATA) && !i_ce &&
                      (abort_pend_q || (S_AXIN_ABORT && !sent_last_q));
      if (ev_send) begin
         h_v_d       = 1'b0;
         sent_last_d = h_l_q;
      end
      if (S_AXIN_ABORT || (state_q == DRAIN)) h_v_d = 1'b0;
      if (load) begin
         h_v_d = 1'b1;
         h_d_d = S_AXIN_DATA;
         h_l_d = S_AXIN_LAST;
      end
      case (state_q)
         IDLE: if (ev_send) state_d = DATA;
         DATA: begin
            if (ev_end) begin
               state_d = GAP;
               cnt_d   = CNT_LOAD;
            end else if (ev_trunc) begin
               state_d       = DRAIN;
               cause_abort_d = abort_now;
               abort_seen_d  = 1'b0;
            end
         end
         DRAIN: begin
            if (S_AXIN_ABORT) abort_seen_d = 1'b1;
            if (drain_done) begin
               state_d = GAP;
               cnt_d   = CNT_LOAD;
            end
         end
         GAP: begin
            if (i_ce) begin
               if (cnt_q == '0) state_d = IDLE;
               else             cnt_d   = cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      o_v_d   = o_v_q;
      o_d_d   = o_d_q;
      o_err_d = ev_trunc;
      if (ev_send) begin
         o_v_d = 1'b1;
         o_d_d = h_d_q;
      end else if (ev_end || ev_trunc) begin
         o_v_d = 1'b0;
      end
   end

   assign o_v    = o_v_q;
   assign o_d    = o_d_q;
   assign o_err  = o_err_q;
   assign o_busy = (state_q != IDLE);

endmodule

// File: tb/tb_txepacket.sv
// Randomized bench for txepacket: packets in, frames observed per PHY strobe and
// compared against the byte sequences each scenario should produce.
module tb_txepacket;

   localparam int GAP = 12;

   logic       clk = 1'b0;
   logic       rst, ce, valid, ready, last, abort, ov, err, busy;
   logic [7:0] data, od;

   txepacket #(.GAP_BYTES(GAP)) dut (
      .i_clk(clk), .i_reset(rst), .i_ce(ce),
      .S_AXIN_VALID(valid), .S_AXIN_READY(ready), .S_AXIN_DATA(data),
      .S_AXIN_LAST(last), .S_AXIN_ABORT(abort),
      .o_v(ov), .o_d(od), .o_err(err), .o_busy(busy)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0;
   logic [7:0] act_bytes[$], exp_bytes[$], pkt_q[$];
   int act_lens[$], exp_lens[$], act_gaps[$];
   int act_err = 0, consec_err = 0, ce_viol = 0, idle_run = 0;
   bit frame_open = 0, seen_frame = 0, prev_err = 0, ce_edge = 0, prev_ov = 0;
   logic [7:0] prev_od = 8'd0;
   bit ce_en = 0;
   int ce_period = 2, ce_ph = 0;

   // strobe generator
   always @(negedge clk) begin
      if (!ce_en) begin
         ce = 1'b0;
         ce_ph = 0;
      end else begin
         if (ce_ph >= ce_period) ce_ph = 0;
         ce = (ce_ph == 0);
         ce_ph = ce_ph + 1;
      end
   end

   always @(posedge clk) ce_edge <= ce;

   // frame monitor: one sample per byte-time
   always @(negedge clk) begin
      if (rst) begin
         frame_open = 0;
         prev_err = 0;
         prev_ov = ov;
         prev_od = od;
      end else begin
         if (err) begin
            act_err++;
            if (prev_err) consec_err++;
         end
         prev_err = err;
         if (!ce_edge && (ov !== prev_ov || od !== prev_od)) ce_viol++;
         prev_ov = ov;
         prev_od = od;
         if (ce_edge) begin
            if (ov) begin
               if (!frame_open) begin
                  frame_open = 1;
                  act_lens.push_back(0);
                  if (seen_frame) act_gaps.push_back(idle_run);
               end
               act_bytes.push_back(od);
               act_lens[act_lens.size()-1] += 1;
            end else begin
               if (frame_open) begin
                  frame_open = 0;
                  seen_frame = 1;
                  idle_run = 0;
               end
               idle_run++;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog time_limit reached required=finish");
      $fatal(1, "watchdog");
   end

   function automatic int frame_diffs();
      int d = 0;
      if (act_lens.size() != exp_lens.size()) d++;
      for (int i = 0; i < act_lens.size() && i < exp_lens.size(); i++)
         if (act_lens[i] != exp_lens[i]) d++;
      if (act_bytes.size() != exp_bytes.size()) d++;
      for (int i = 0; i < act_bytes.size() && i < exp_bytes.size(); i++)
         if (act_bytes[i] !== exp_bytes[i]) d++;
      return d;
   endfunction

   task automatic clear_model();
      act_bytes.delete(); exp_bytes.delete();
      act_lens.delete();  exp_lens.delete(); act_gaps.delete();
      act_err = 0; seen_frame = 0; idle_run = 0;
   endtask

   task automatic expect_frame(input int n);
      for (int i = 0; i < n; i++) exp_bytes.push_back(pkt_q[i]);
      exp_lens.push_back(n);
   endtask

   task automatic rand_pkt(input int n);
      pkt_q.delete();
      for (int i = 0; i < n; i++) pkt_q.push_back(8'($urandom));
   endtask

   task automatic send_beat(input logic [7:0] d, input logic l, output int waits);
      @(negedge clk);
      valid = 1'b1; data = d; last = l;
      #1;
      waits = 0;
      while (!ready && waits < 2000) begin
         @(negedge clk); #1; waits++;
      end
      if (waits >= 2000) begin
         total++; bad++;
         $display("FAIL beat_timeout ready=%b required=1", ready);
      end
   endtask

   task automatic end_beats();
      @(negedge clk);
      valid = 1'b0; last = 1'b0;
   endtask

   task automatic send_pkt();
      int w;
      for (int i = 0; i < pkt_q.size(); i++) send_beat(pkt_q[i], i == pkt_q.size() - 1, w);
      end_beats();
      $display("pkt sent len=%0d first=%02h ce_period=%0d", pkt_q.size(), pkt_q[0], ce_period);
   endtask

   task automatic wait_idle();
      int n = 0;
      repeat (10) @(negedge clk);
      #1;
      while (!(!busy && !ov && ready) && n < 5000) begin
         @(negedge clk); #1; n++;
      end
      if (n >= 5000) begin
         total++; bad++;
         $display("FAIL idle_timeout busy=%b required=0", busy);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      #1;
      total++; if (ov !== 1'b0)    begin bad++; $display("FAIL reset_ov got=%b want=0", ov); end
      total++; if (od !== 8'h00)   begin bad++; $display("FAIL reset_od got=%h want=00", od); end
      total++; if (err !== 1'b0)   begin bad++; $display("FAIL reset_err got=%b want=0", err); end
      total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready); end
      @(negedge clk);
      rst = 1'b0;
      ce_en = 1;
   endtask

   task automatic test_stream();
      clear_model();
      ce_period = 2;
      pkt_q = '{8'h11, 8'h22, 8'h33, 8'h44};
      expect_frame(4);
      send_pkt();
      wait_idle();
      total++; if (act_lens.size() !== 1 || act_lens[0] !== 4) begin bad++;
         $display("FAIL stream_len frames=%0d want=1 len_want=4", act_lens.size()); end
      total++; if (frame_diffs() !== 0) begin bad++;
         $display("FAIL stream_bytes diffs=%0d want=0", frame_diffs()); end
      for (int r = 0; r < 6; r++) begin
         ce_period = $urandom_range(2, 5);
         rand_pkt($urandom_range(1, 8));
         expect_frame(pkt_q.size());
         send_pkt();
         wait_idle();
      end
      total++; if (frame_diffs() !== 0) begin bad++;
         $display("FAIL stream_random diffs=%0d want=0 frames=%0d want=%0d",
                  frame_diffs(), act_lens.size(), exp_lens.size()); end
      total++; if (act_err !== 0) begin bad++; $display("FAIL stream_err got=%0d want=0", act_err); end
   endtask

   task automatic test_back_to_back();
      clear_model();
      ce_period = 4;
      rand_pkt(3); expect_frame(3); send_pkt();
      rand_pkt(3); expect_frame(3); send_pkt();
      wait_idle();
      total++; if (frame_diffs() !== 0) begin bad++;
         $display("FAIL b2b_frames diffs=%0d want=0 frames=%0d", frame_diffs(), act_lens.size()); end
      total++; if (act_gaps.size() !== 1) begin bad++;
         $display("FAIL b2b_gapcount got=%0d want=1", act_gaps.size()); end
      else if (act_gaps[0] < GAP || act_gaps[0] > GAP + 1) begin bad++;
         $display("FAIL b2b_gap got=%0d want=%0d..%0d", act_gaps[0], GAP, GAP + 1); end
      total++; if (act_err !== 0) begin bad++; $display("FAIL b2b_err got=%0d want=0", act_err); end
   endtask

   task automatic test_underrun();
      int w;
      clear_model();
      ce_period = $urandom_range(2, 4);
      rand_pkt(5);
      expect_frame(2);
      send_beat(pkt_q[0], 1'b0, w);
      send_beat(pkt_q[1], 1'b0, w);
      end_beats();
      repeat (8 * ce_period) @(negedge clk);
      for (int i = 2; i < 5; i++) begin
         send_beat(pkt_q[i], i == 4, w);
         total++; if (w !== 0) begin bad++;
            $display("FAIL underrun_drain_ready beat=%0d waits=%0d want=0", i, w); end
      end
      end_beats();
      $display("pkt sent len=5 underrun after 2 bytes");
      wait_idle();
      rand_pkt($urandom_range(2, 6)); expect_frame(pkt_q.size()); send_pkt();
      wait_idle();
      total++; if (frame_diffs() !== 0) begin bad++;
         $display("FAIL underrun_frames diffs=%0d want=0 frames=%0d", frame_diffs(), act_lens.size()); end
      total++; if (act_err !== 1) begin bad++; $display("FAIL underrun_err got=%0d want=1", act_err); end
   endtask

   task automatic test_abort();
      int w, n;
      clear_model();
      ce_period = $urandom_range(2, 4);
      rand_pkt(6);
      expect_frame(3);
      for (int i = 0; i < 3; i++) send_beat(pkt_q[i], 1'b0, w);
      end_beats();
      n = 0;
      #1;
      while (act_bytes.size() < 3 && n < 2000) begin @(negedge clk); #1; n++; end
      total++; if (n >= 2000) begin bad++;
         $display("FAIL abort_wait bytes=%0d want=3", act_bytes.size()); end
      abort = 1'b1; valid = 1'b1; data = pkt_q[3];
      #1;
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b want=1", ready); end
      @(negedge clk);
      abort = 1'b0; valid = 1'b0;
      $display("pkt sent len=6 aborted during byte 3");
      wait_idle();
      rand_pkt($urandom_range(2, 6)); expect_frame(pkt_q.size()); send_pkt();
      wait_idle();
      total++; if (frame_diffs() !== 0) begin bad++;
         $display("FAIL abort_frames diffs=%0d want=0 frames=%0d", frame_diffs(), act_lens.size()); end
      total++; if (act_err !== 1) begin bad++; $display("FAIL abort_err got=%0d want=1", act_err); end
   endtask

   task automatic test_async_reset();
      int w, n;
      clear_model();
      ce_period = 2;
      rand_pkt(6);
      for (int i = 0; i < 3; i++) send_beat(pkt_q[i], 1'b0, w);
      end_beats();
      n = 0;
      #1;
      while (act_bytes.size() < 2 && n < 2000) begin @(negedge clk); #1; n++; end
      total++; if (ov !== 1'b1) begin bad++; $display("FAIL areset_pre_ov got=%b want=1", ov); end
      #3 rst = 1'b1;
      #1;
      $display("reset asserted mid-frame at t=%0t", $time);
      total++; if (ov !== 1'b0)   begin bad++; $display("FAIL areset_ov got=%b want=0", ov); end
      total++; if (err !== 1'b0)  begin bad++; $display("FAIL areset_err got=%b want=0", err); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL areset_busy got=%b want=0", busy); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      clear_model();
      rand_pkt($urandom_range(2, 7)); expect_frame(pkt_q.size()); send_pkt();
      wait_idle();
      total++; if (frame_diffs() !== 0) begin bad++;
         $display("FAIL areset_frames diffs=%0d want=0 frames=%0d", frame_diffs(), act_lens.size()); end
      total++; if (act_err !== 0) begin bad++; $display("FAIL areset_err_after got=%0d want=0", act_err); end
   endtask

   task automatic test_idle_abort();
      int w;
      clear_model();
      ce_en = 0;
      repeat (2) @(negedge clk);
      send_beat(8'($urandom), 1'b1, w);
      end_beats();
      #1;
      total++; if (ready !== 1'b0) begin bad++; $display("FAIL idle_abort_loaded ready=%b want=0", ready); end
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      $display("pkt sent len=1 aborted while idle");
      ce_period = 2;
      ce_en = 1;
      repeat (40) @(negedge clk);
      #1;
      total++; if (act_lens.size() !== 0) begin bad++;
         $display("FAIL idle_abort_frames got=%0d want=0", act_lens.size()); end
      total++; if (act_err !== 0) begin bad++; $display("FAIL idle_abort_err got=%0d want=0", act_err); end
      total++; if (ready !== 1'b1 || busy !== 1'b0) begin bad++;
         $display("FAIL idle_abort_state ready=%b busy=%b want ready=1 busy=0", ready, busy); end
   endtask

   initial begin
      rst = 1'b1; valid = 1'b0; data = 8'd0; last = 1'b0; abort = 1'b0;
      test_reset();
      test_stream();
      test_back_to_back();
      test_underrun();
      test_abort();
      test_async_reset();
      test_idle_abort();
      total++; if (consec_err !== 0) begin bad++; $display("FAIL err_consecutive got=%0d want=0", consec_err); end
      total++; if (ce_viol !== 0) begin bad++; $display("FAIL output_off_strobe got=%0d want=0", ce_viol); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
